// File: rtl/audio_pkg.sv
// Shared types for the two-clip voice recorder sequencer.
package audio_pkg;

    localparam int NUM_CLIPS = 2;
    localparam int ADDR_W    = 17;
    localparam int CLIP_W    = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;

    typedef logic [CLIP_W-1:0] clip_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2,
        HOLD = 2'd3
    } seq_state_e;

endpackage

// File: rtl/audio_clip_sequencer_addr_gen.sv
// Shared BRAM address counter with clear, increment and terminal compare (addr == limit-1).
module clip_addr_gen #(
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W:0]   limit,
    output logic [ADDR_W-1:0] addr,
    output logic              at_term
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (clear) begin
            addr_d = '0;
        end else if (inc) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr    = addr_q;
    assign at_term = ({1'b0, addr_q} == (limit - 1'b1));

endmodule

// File: rtl/audio_clip_sequencer.sv
// Record/playback sequencer owning the per-clip BRAM enables, shared address and clip lengths.
// Build option: define LOOP_PLAYBACK_EN to wrap playback at end of clip while play is held.
//
// state | meaning
// IDLE  | waiting for a button; record beats play
// REC   | deserializer running, each des_done writes one sample
// PLAY  | serializer running, each ser_done advances the read address
// HOLD  | enables off until both buttons are released
module audio_clip_sequencer #(
    parameter int NUM_CLIPS   = 2,
    parameter int ADDR_W      = 17,
    parameter int MAX_SAMPLES = 2**ADDR_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         play_req,
    input  logic                         record_req,
    input  logic [$clog2(NUM_CLIPS)-1:0] clip_play_num,
    input  logic [$clog2(NUM_CLIPS)-1:0] clip_rec_num,
    input  logic                         des_done,
    input  logic                         ser_done,
    output logic                         des_enable,
    output logic                         ser_enable,
    output logic [NUM_CLIPS-1:0]         mem_en,
    output logic [NUM_CLIPS-1:0]         mem_wen,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [$clog2(NUM_CLIPS)-1:0] play_sel,
    output logic [NUM_CLIPS-1:0]         clip_valid,
    output logic                         busy
);

    import audio_pkg::*;

    localparam int CW = $clog2(NUM_CLIPS);
    localparam int LW = ADDR_W + 1;

    seq_state_e      state_q, state_d;
    logic [CW-1:0]   clip_q, clip_d;
    logic [LW-1:0]   len_q [NUM_CLIPS];
    logic [LW-1:0]   len_d [NUM_CLIPS];

    logic              addr_clr;
    logic              addr_inc;
    logic [LW-1:0]     addr_limit;
    logic [ADDR_W-1:0] addr;
    logic              addr_term;

    clip_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .clear   (addr_clr),
        .inc     (addr_inc),
        .limit   (addr_limit),
        .addr    (addr),
        .at_term (addr_term)
    );

    always_comb begin
        state_d    = state_q;
        clip_d     = clip_q;
        len_d      = len_q;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        addr_limit = LW'(MAX_SAMPLES);
        des_enable = 1'b0;
        ser_enable = 1'b0;
        mem_en     = '0;
        mem_wen    = '0;
        mem_addr   = '0;
        play_sel   = '0;

        case (state_q)
            IDLE: begin
                if (record_req) begin
                    state_d              = REC;
                    clip_d               = clip_rec_num;
                    addr_clr             = 1'b1;
                    len_d[clip_rec_num]  = '0;
                end else if (play_req && (len_q[clip_play_num] != '0)) begin
                    state_d  = PLAY;
                    clip_d   = clip_play_num;
                    addr_clr = 1'b1;
                end
            end

            REC: begin
                des_enable     = 1'b1;
                mem_en[clip_q] = 1'b1;
                mem_addr       = addr;
                if (des_done) begin
                    mem_wen[clip_q] = 1'b1;
                    addr_inc        = !addr_term;
                end
                // A sample arriving with the button release is still counted.
                if (!record_req || (des_done && addr_term)) begin
                    state_d       = HOLD;
                    len_d[clip_q] = {1'b0, addr} + LW'(des_done);
                end
            end

            PLAY: begin
                addr_limit     = len_q[clip_q];
                ser_enable     = 1'b1;
                mem_en[clip_q] = 1'b1;
                mem_addr       = addr;
                play_sel       = clip_q;
                if (!play_req || record_req) begin
                    state_d = HOLD;
                end else if (ser_done) begin
                    if (addr_term) begin
`ifdef LOOP_PLAYBACK_EN
                        addr_clr = 1'b1;
`else
                        state_d = HOLD;
`endif
                    end else begin
                        addr_inc = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (!play_req && !record_req) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            clip_q  <= '0;
            for (int i = 0; i < NUM_CLIPS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            clip_q  <= clip_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLIPS; i++) begin
            clip_valid[i] = (len_q[i] != '0);
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Directed bench for audio_clip_sequencer (MAX_SAMPLES=8); follows LOOP_PLAYBACK_EN when defined.
module tb_audio_clip_sequencer;

`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        play_req, record_req;
    logic [0:0]  clip_play_num, clip_rec_num;
    logic        des_done, ser_done;
    logic        des_enable, ser_enable;
    logic [1:0]  mem_en, mem_wen;
    logic [16:0] mem_addr;
    logic [0:0]  play_sel;
    logic [1:0]  clip_valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    audio_clip_sequencer #(
        .NUM_CLIPS   (2),
        .ADDR_W      (17),
        .MAX_SAMPLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .play_req      (play_req),
        .record_req    (record_req),
        .clip_play_num (clip_play_num),
        .clip_rec_num  (clip_rec_num),
        .des_done      (des_done),
        .ser_done      (ser_done),
        .des_enable    (des_enable),
        .ser_enable    (ser_enable),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .play_sel      (play_sel),
        .clip_valid    (clip_valid),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {7'b0, busy, des_enable, ser_enable, mem_en, mem_wen, play_sel, mem_addr};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b0; play_req = 1'b0; record_req = 1'b0;
        clip_play_num = '0; clip_rec_num = '0; des_done = 1'b0; ser_done = 1'b0;
        tick(); tick();
        chk("rst_outs", outs(), 32'h0);
        chk("rst_valid", 32'(clip_valid), 32'h0);
        reset = 1'b1;
        tick();

        // record 5 samples into clip 0
        record_req = 1'b1; clip_rec_num = 1'b0;
        tick();
        chk("rec0_en", {27'b0, busy, des_enable, ser_enable, mem_en}, {27'b0, 5'b1_1_0_01});
        for (int i = 0; i < 5; i++) begin
            des_done = 1'b1; #1;
            chk("rec0_wen", 32'(mem_wen), 32'h1);
            chk("rec0_addr", 32'(mem_addr), 32'(i));
            tick();
            des_done = 1'b0;
            tick();
        end
        record_req = 1'b0;
        tick();
        chk("rec0_hold", {27'b0, busy, des_enable, ser_enable, mem_en}, {27'b0, 5'b1_0_0_00});
        chk("rec0_valid", 32'(clip_valid), 32'h1);
        tick();
        chk("rec0_idle", outs(), 32'h0);

        // play clip 0 (len 5)
        play_req = 1'b1; clip_play_num = 1'b0;
        tick();
        chk("play0_en", {27'b0, des_enable, ser_enable, mem_en, play_sel}, {27'b0, 5'b0_1_01_0});
        for (int i = 0; i < 5; i++) begin
            chk("play0_addr", 32'(mem_addr), 32'(i));
            ser_done = 1'b1;
            tick();
            ser_done = 1'b0;
        end
        chk("play0_end_ser", 32'(ser_enable), 32'(LOOP));
        chk("play0_end_addr", 32'(mem_addr), 32'h0);
        play_req = 1'b0;
        tick(); tick();
        chk("play0_idle", outs(), 32'h0);

        // play of an empty clip is ignored
        play_req = 1'b1; clip_play_num = 1'b1;
        tick(); tick();
        chk("empty_play", outs(), 32'h0);
        play_req = 1'b0;
        tick();

        // both requests together: record clip 1 wins, 3 samples
        play_req = 1'b1; record_req = 1'b1; clip_rec_num = 1'b1; clip_play_num = 1'b0;
        tick();
        chk("both_rec", {27'b0, busy, des_enable, ser_enable, mem_en}, {27'b0, 5'b1_1_0_10});
        for (int i = 0; i < 3; i++) begin
            des_done = 1'b1; #1;
            chk("rec1_wen", 32'(mem_wen), 32'h2);
            chk("rec1_addr", 32'(mem_addr), 32'(i));
            tick();
            des_done = 1'b0;
            tick();
        end
        play_req = 1'b0; record_req = 1'b0;
        tick();
        chk("rec1_valid", 32'(clip_valid), 32'h3);
        tick();
        chk("rec1_idle", outs(), 32'h0);

        // fill clip 0: 10 des_done, only 8 written
        record_req = 1'b1; clip_rec_num = 1'b0;
        tick();
        chk("rerec_clear", 32'(clip_valid), 32'h2);
        for (int i = 0; i < 10; i++) begin
            des_done = 1'b1; #1;
            chk("full_wen", 32'(mem_wen), (i < 8) ? 32'h1 : 32'h0);
            chk("full_addr", 32'(mem_addr), (i < 8) ? 32'(i) : 32'h0);
            tick();
            des_done = 1'b0;
            tick();
        end
        chk("full_hold", {28'b0, busy, des_enable, mem_en}, {28'b0, 4'b1_0_00});
        chk("full_valid", 32'(clip_valid), 32'h3);
        record_req = 1'b0;
        tick();
        chk("full_idle", outs(), 32'h0);

        // play clip 0: length must be 8
        play_req = 1'b1; clip_play_num = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("play8_addr", 32'(mem_addr), 32'(i));
            ser_done = 1'b1;
            tick();
            ser_done = 1'b0;
        end
        chk("play8_end_ser", 32'(ser_enable), 32'(LOOP));
        play_req = 1'b0;
        tick(); tick();
        chk("play8_idle", outs(), 32'h0);

        // clip 1 (len 3), 7 ser_done with play held
        play_req = 1'b1; clip_play_num = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("loop_addr", 32'(mem_addr), LOOP ? 32'(i % 3) : ((i < 3) ? 32'(i) : 32'h0));
            chk("loop_ser", 32'(ser_enable), (LOOP || i < 3) ? 32'h1 : 32'h0);
            ser_done = 1'b1;
            tick();
            ser_done = 1'b0;
        end
        play_req = 1'b0;
        tick(); tick();
        chk("loop_idle", outs(), 32'h0);

        // record request during playback forces HOLD, not REC
        play_req = 1'b1; clip_play_num = 1'b1;
        tick();
        chk("pre_play_sel", {30'b0, ser_enable, play_sel}, {30'b0, 2'b11});
        record_req = 1'b1;
        tick();
        chk("rec_in_play", {27'b0, busy, des_enable, ser_enable, mem_en}, {27'b0, 5'b1_0_0_00});
        play_req = 1'b0;
        tick();
        chk("hold_rec_held", 32'(busy), 32'h1);
        record_req = 1'b0;
        tick();
        chk("hold_release", outs(), 32'h0);

        // reset in the middle of a recording
        record_req = 1'b1; clip_rec_num = 1'b1;
        tick();
        des_done = 1'b1;
        tick();
        des_done = 1'b0;
        chk("midrec_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        tick();
        chk("midrec_rst_outs", outs(), 32'h0);
        chk("midrec_rst_valid", 32'(clip_valid), 32'h0);
        reset = 1'b1; record_req = 1'b0;
        tick();
        chk("post_rst_idle", outs(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
